// File: rtl/note_seq_pkg.sv
// -----------------------------------------------------------------------------
// note_seq_pkg
// Shared definitions for the note-sequence ROM format and the playback FSM.
//   - Field widths of a ROM entry and of the ROM address.
//   - Bit positions of each field inside a 16-bit ROM word, so ROM converters
//     and the sequencer agree on the layout.
//   - Sequencer state encoding.
//   - pack_entry(): builds a ROM word from its three fields.
// -----------------------------------------------------------------------------
package note_seq_pkg;

  localparam int NOTE_W  = 5;
  localparam int DELAY_W = 10;
  localparam int ADDR_W  = 8;
  localparam int ROM_W   = 16;

  // ROM word layout: [15] note_on, [14:10] note index, [9:0] delay units.
  localparam int ROM_NOTE_ON_BIT = 15;
  localparam int ROM_NOTE_MSB    = 14;
  localparam int ROM_NOTE_LSB    = 10;
  localparam int ROM_DELAY_MSB   = 9;
  localparam int ROM_DELAY_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_HOLD
  } seq_state_t;

  function automatic logic [ROM_W-1:0] pack_entry(
    input logic               note_on,
    input logic [NOTE_W-1:0]  note,
    input logic [DELAY_W-1:0] delay
  );
    logic [ROM_W-1:0] word;
    word = '0;
    word[ROM_NOTE_ON_BIT]             = note_on;
    word[ROM_NOTE_MSB:ROM_NOTE_LSB]   = note;
    word[ROM_DELAY_MSB:ROM_DELAY_LSB] = delay;
    return word;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider: o_tick is high for one cycle every TICK_DIV cycles.
// i_clear holds the count at 0, so the first tick after clear is released
// arrives exactly TICK_DIV cycles later.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high reset
//   i_clear  in   hold the prescaler at 0 (suppresses o_tick)
//   o_tick   out  one-cycle pulse on the last count of each period
// -----------------------------------------------------------------------------
module tick_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_tick
);

  // TICK_DIV = 1 needs no count bits, but a 1-bit register keeps the code uniform.
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_LAST);
  assign o_tick = w_wrap && !i_clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Playback controller for a note-sequence ROM. Walks the ROM address, waits
// out the ROM read latency, latches each entry's note and holds it for
// rom_delay * TICK_DIV cycles, then advances (optionally looping).
// Per-entry period: ROM_LAT + 1 + rom_delay * TICK_DIV cycles.
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   start        in   pulse: begin playback from address 0 (IDLE only)
//   stop         in   pulse: abort playback (wins over start)
//   loop_en      in   at end of last entry: 1 = wrap to address 0
//   rom_addr     out  ROM address
//   rom_note_on  in   ROM gate field
//   rom_note     in   ROM note index field
//   rom_delay    in   ROM delay field, in units of TICK_DIV cycles
//   note_on      out  registered gate to the tone generator
//   note         out  registered note index
//   playing      out  high in any state but IDLE
//   song_done    out  one-cycle pulse on non-looping completion
// -----------------------------------------------------------------------------
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int SONG_LEN = 146,
  parameter int TICK_DIV = 50000,
  parameter int ROM_LAT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_en,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic               rom_note_on,
  input  logic [NOTE_W-1:0]  rom_note,
  input  logic [DELAY_W-1:0] rom_delay,
  output logic               note_on,
  output logic [NOTE_W-1:0]  note,
  output logic               playing,
  output logic               song_done
);

  localparam int                WAIT_W    = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);

  seq_state_t         r_state,   w_state_nxt;
  logic [ADDR_W-1:0]  r_addr,    w_addr_nxt;
  logic [WAIT_W-1:0]  r_wait,    w_wait_nxt;
  logic [DELAY_W-1:0] r_delay,   w_delay_nxt;
  logic [NOTE_W-1:0]  r_note,    w_note_nxt;
  logic               r_note_on, w_note_on_nxt;
  logic               r_done,    w_done_nxt;
  logic               w_advance;
  logic               w_tick;
  logic               w_pre_clear;

  // The prescaler only runs in HOLD; everywhere else it sits at 0, so each
  // HOLD starts a fresh TICK_DIV period.
  assign w_pre_clear = (r_state != ST_HOLD);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_pre_clear),
    .o_tick  (w_tick)
  );

  always_comb begin
    // NOTE: every value written here gets a default first, so no latch is inferred.
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wait_nxt    = '0;
    w_delay_nxt   = r_delay;
    w_note_nxt    = r_note;
    w_note_on_nxt = r_note_on;
    w_done_nxt    = 1'b0;
    w_advance     = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        w_addr_nxt = '0;
        if (start && !stop) begin
          w_state_nxt = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (r_wait == WAIT_LAST) begin
          w_state_nxt = ST_LATCH;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end

      ST_LATCH: begin
        w_note_nxt    = rom_note;
        w_note_on_nxt = rom_note_on;
        w_delay_nxt   = rom_delay;
        if (rom_delay == '0) begin
          w_advance = 1'b1;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end

      ST_HOLD: begin
        // r_delay is never 0 here: HOLD is entered only with a non-zero delay
        // and left on the tick that takes it from 1 to 0.
        if (w_tick) begin
          w_delay_nxt = r_delay - DELAY_W'(1);
          if (r_delay == DELAY_W'(1)) begin
            w_advance = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Advance decision shared by LATCH (zero delay) and HOLD (delay expired).
    if (w_advance) begin
      if (r_addr < LAST_ADDR) begin
        w_addr_nxt  = r_addr + ADDR_W'(1);
        w_state_nxt = ST_FETCH;
      end else if (loop_en) begin
        w_addr_nxt  = '0;
        w_state_nxt = ST_FETCH;
      end else begin
        w_addr_nxt    = '0;
        w_note_on_nxt = 1'b0;
        w_done_nxt    = 1'b1;
        w_state_nxt   = ST_IDLE;
      end
    end

    // stop overrides everything above, including a completion in the same cycle.
    if (stop && (r_state != ST_IDLE)) begin
      w_state_nxt   = ST_IDLE;
      w_addr_nxt    = '0;
      w_wait_nxt    = '0;
      w_delay_nxt   = '0;
      w_note_nxt    = r_note;
      w_note_on_nxt = 1'b0;
      w_done_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_wait    <= '0;
      r_delay   <= '0;
      r_note    <= '0;
      r_note_on <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_wait    <= w_wait_nxt;
      r_delay   <= w_delay_nxt;
      r_note    <= w_note_nxt;
      r_note_on <= w_note_on_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign rom_addr  = r_addr;
  assign note      = r_note;
  assign note_on   = r_note_on;
  assign song_done = r_done;
  assign playing   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_note_sequencer.sv
// -----------------------------------------------------------------------------
// tb_note_sequencer
// Directed bench. u_dut: SONG_LEN=3, TICK_DIV=4, ROM_LAT=2 with a 2-cycle
// behavioural ROM holding {on,9,2},{off,9,1},{on,8,0}.
// u_fast: SONG_LEN=1, TICK_DIV=1 with a single entry {on,3,1023}.
// Cycle n means "observed 1 time unit after the n-th rising edge following
// the edge that captured start" (n=0 is the first FETCH cycle).
// Entry periods with TICK_DIV=4: 3+8, 3+4, 3+0 -> IDLE after edge 21.
// -----------------------------------------------------------------------------
module tb_note_sequencer;
  import note_seq_pkg::*;

  logic clk;
  logic reset;
  logic start, stop, loop_en;
  logic [ADDR_W-1:0]  rom_addr;
  logic               rom_note_on;
  logic [NOTE_W-1:0]  rom_note;
  logic [DELAY_W-1:0] rom_delay;
  logic               note_on, playing, song_done;
  logic [NOTE_W-1:0]  note;

  logic start2;
  logic [ADDR_W-1:0]  rom_addr2;
  logic               note_on2, playing2, song_done2;
  logic [NOTE_W-1:0]  note2;
  logic [ROM_W-1:0]   word2;

  int errors = 0;
  int checks = 0;

  // Behavioural ROM with two cycles of read latency.
  logic [ROM_W-1:0]  rom_mem [0:3];
  logic [ADDR_W-1:0] a1, a2;
  logic [ROM_W-1:0]  rom_word;

  always @(posedge clk) begin
    a1 <= rom_addr;
    a2 <= a1;
  end

  always_comb begin
    rom_word = (a2 < 8'd4) ? rom_mem[a2[1:0]] : '0;
  end

  assign rom_note_on = rom_word[ROM_NOTE_ON_BIT];
  assign rom_note    = rom_word[ROM_NOTE_MSB:ROM_NOTE_LSB];
  assign rom_delay   = rom_word[ROM_DELAY_MSB:ROM_DELAY_LSB];

  note_sequencer #(.SONG_LEN(3), .TICK_DIV(4), .ROM_LAT(2)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .loop_en     (loop_en),
    .rom_addr    (rom_addr),
    .rom_note_on (rom_note_on),
    .rom_note    (rom_note),
    .rom_delay   (rom_delay),
    .note_on     (note_on),
    .note        (note),
    .playing     (playing),
    .song_done   (song_done)
  );

  // Single-entry ROM: content does not depend on address, so latency is moot.
  note_sequencer #(.SONG_LEN(1), .TICK_DIV(1), .ROM_LAT(2)) u_fast (
    .clk         (clk),
    .reset       (reset),
    .start       (start2),
    .stop        (1'b0),
    .loop_en     (1'b0),
    .rom_addr    (rom_addr2),
    .rom_note_on (word2[ROM_NOTE_ON_BIT]),
    .rom_note    (word2[ROM_NOTE_MSB:ROM_NOTE_LSB]),
    .rom_delay   (word2[ROM_DELAY_MSB:ROM_DELAY_LSB]),
    .note_on     (note_on2),
    .note        (note2),
    .playing     (playing2),
    .song_done   (song_done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({rom_addr, note_on, note, playing, song_done} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got addr=%0d on=%0b note=%0d play=%0b done=%0b, want all 0",
               rom_addr, note_on, note, playing, song_done);
    end
    checks++;
    if ({rom_addr2, note_on2, note2, playing2, song_done2} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state_fast: got addr=%0d on=%0b note=%0d play=%0b done=%0b, want all 0",
               rom_addr2, note_on2, note2, playing2, song_done2);
    end
  endtask

  task automatic test_single_pass();
    int ea, eo, en, ep, ed;
    loop_en = 1'b0;
    pulse_start();
    for (int n = 0; n <= 22; n++) begin
      ea = (n <= 10) ? 0 : (n <= 17) ? 1 : (n <= 20) ? 2 : 0;
      eo = (n >= 3 && n <= 13) ? 1 : 0;
      en = (n <= 2) ? 0 : (n <= 20) ? 9 : 8;
      ep = (n <= 20) ? 1 : 0;
      ed = (n == 21) ? 1 : 0;
      checks++;
      if (rom_addr !== ADDR_W'(ea) || note_on !== eo[0] || note !== NOTE_W'(en) ||
          playing !== ep[0] || song_done !== ed[0]) begin
        errors++;
        $display("FAIL single_pass n=%0d: got addr=%0d on=%0b note=%0d play=%0b done=%0b, want %0d %0d %0d %0d %0d",
                 n, rom_addr, note_on, note, playing, song_done, ea, eo, en, ep, ed);
      end
      step();
    end
  endtask

  task automatic test_loop();
    int m, ea, eo;
    loop_en = 1'b1;
    pulse_start();
    for (int n = 0; n <= 62; n++) begin
      m  = n % 21;
      ea = (m <= 10) ? 0 : (m <= 17) ? 1 : 2;
      eo = (n < 3) ? 0 : (m <= 13) ? 1 : 0;
      checks++;
      if (rom_addr !== ADDR_W'(ea) || note_on !== eo[0] || playing !== 1'b1 || song_done !== 1'b0) begin
        errors++;
        $display("FAIL loop n=%0d: got addr=%0d on=%0b play=%0b done=%0b, want %0d %0d 1 0",
                 n, rom_addr, note_on, playing, song_done, ea, eo);
      end
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    loop_en = 1'b0;
    checks++;
    if (playing !== 1'b0 || rom_addr !== 8'd0 || note_on !== 1'b0 || song_done !== 1'b0) begin
      errors++;
      $display("FAIL loop_stop: got play=%0b addr=%0d on=%0b done=%0b, want 0 0 0 0",
               playing, rom_addr, note_on, song_done);
    end
    step();
  endtask

  task automatic test_stop_hold();
    loop_en = 1'b0;
    pulse_start();
    for (int n = 0; n < 15; n++) step();
    checks++;
    if (rom_addr !== 8'd1 || note_on !== 1'b0 || note !== 5'd9 || playing !== 1'b1) begin
      errors++;
      $display("FAIL stop_pre: got addr=%0d on=%0b note=%0d play=%0b, want 1 0 9 1",
               rom_addr, note_on, note, playing);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (rom_addr !== 8'd0 || note_on !== 1'b0 || note !== 5'd9 || playing !== 1'b0 || song_done !== 1'b0) begin
      errors++;
      $display("FAIL stop_hold: got addr=%0d on=%0b note=%0d play=%0b done=%0b, want 0 0 9 0 0",
               rom_addr, note_on, note, playing, song_done);
    end
    for (int n = 0; n < 6; n++) begin
      step();
      checks++;
      if (song_done !== 1'b0 || playing !== 1'b0) begin
        errors++;
        $display("FAIL stop_quiet k=%0d: got done=%0b play=%0b, want 0 0", n, song_done, playing);
      end
    end
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (playing !== 1'b0 || rom_addr !== 8'd0) begin
        errors++;
        $display("FAIL start_stop_idle k=%0d: got play=%0b addr=%0d, want 0 0", n, playing, rom_addr);
      end
      step();
    end
  endtask

  task automatic test_start_ignored();
    int ea, ep, ed;
    loop_en = 1'b0;
    pulse_start();
    for (int n = 0; n <= 22; n++) begin
      ea = (n <= 10) ? 0 : (n <= 17) ? 1 : (n <= 20) ? 2 : 0;
      ep = (n <= 20) ? 1 : 0;
      ed = (n == 21) ? 1 : 0;
      checks++;
      if (rom_addr !== ADDR_W'(ea) || playing !== ep[0] || song_done !== ed[0]) begin
        errors++;
        $display("FAIL start_ignored n=%0d: got addr=%0d play=%0b done=%0b, want %0d %0d %0d",
                 n, rom_addr, playing, song_done, ea, ep, ed);
      end
      start = (n == 5);
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_async_reset();
    loop_en = 1'b0;
    pulse_start();
    for (int n = 0; n < 11; n++) step();
    checks++;
    if (rom_addr !== 8'd1 || note_on !== 1'b1 || playing !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: got addr=%0d on=%0b play=%0b, want 1 1 1", rom_addr, note_on, playing);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({rom_addr, note_on, note, playing, song_done} !== 16'h0) begin
      errors++;
      $display("FAIL reset_async: got addr=%0d on=%0b note=%0d play=%0b done=%0b, want all 0",
               rom_addr, note_on, note, playing, song_done);
    end
    #2 reset = 1'b0;
    step();
    step();
    checks++;
    if (playing !== 1'b0) begin
      errors++;
      $display("FAIL reset_stays_idle: got play=%0b, want 0", playing);
    end
    pulse_start();
    for (int n = 0; n <= 3; n++) begin
      checks++;
      if (rom_addr !== 8'd0 || playing !== 1'b1 || note_on !== (n == 3) ||
          note !== ((n == 3) ? 5'd9 : 5'd0)) begin
        errors++;
        $display("FAIL reset_restart n=%0d: got addr=%0d play=%0b on=%0b note=%0d, want 0 1 %0b %0d",
                 n, rom_addr, playing, note_on, note, (n == 3), (n == 3) ? 9 : 0);
      end
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_long_delay();
    int n;
    n = 0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    while (song_done2 !== 1'b1 && n < 2000) begin
      step();
      n++;
      if (n == 3) begin
        checks++;
        if (note_on2 !== 1'b1 || note2 !== 5'd3) begin
          errors++;
          $display("FAIL long_first: got on=%0b note=%0d, want 1 3", note_on2, note2);
        end
      end
      if (n == 1025) begin
        checks++;
        if (note_on2 !== 1'b1 || playing2 !== 1'b1 || song_done2 !== 1'b0) begin
          errors++;
          $display("FAIL long_last_hold: got on=%0b play=%0b done=%0b, want 1 1 0",
                   note_on2, playing2, song_done2);
        end
      end
    end
    checks++;
    if (n != 1026) begin
      errors++;
      $display("FAIL long_period: song_done after %0d cycles, want 1026", n);
    end
    checks++;
    if (note_on2 !== 1'b0 || playing2 !== 1'b0 || note2 !== 5'd3) begin
      errors++;
      $display("FAIL long_end: got on=%0b play=%0b note=%0d, want 0 0 3", note_on2, playing2, note2);
    end
    step();
  endtask

  initial begin
    rom_mem[0] = pack_entry(1'b1, 5'd9, 10'd2);
    rom_mem[1] = pack_entry(1'b0, 5'd9, 10'd1);
    rom_mem[2] = pack_entry(1'b1, 5'd8, 10'd0);
    rom_mem[3] = '0;
    word2   = pack_entry(1'b1, 5'd3, 10'd1023);
    reset   = 1'b1;
    start   = 1'b0;
    stop    = 1'b0;
    loop_en = 1'b0;
    start2  = 1'b0;
    repeat (3) @(posedge clk);
    #6 reset = 1'b0;
    step();
    test_reset();
    test_single_pass();
    step();
    test_loop();
    test_stop_hold();
    test_start_stop_idle();
    test_start_ignored();
    step();
    test_async_reset();
    step();
    test_long_delay();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
